// File: rtl/i2s_rx_pkg.sv
// Shared types and word layout for the I2S receive sample packer.
package i2s_rx_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int WORD_W     = 32;
    localparam int FIRST_MSB  = 31;
    localparam int FIRST_LSB  = 16;
    localparam int SECOND_MSB = 15;
    localparam int SECOND_LSB = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_HAVE_L = 1'b1
    } pk_state_e;

    // Left (stereo) or earlier (mono) sample goes in the upper half.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [SAMPLE_W-1:0] first,
        input logic [SAMPLE_W-1:0] second
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[FIRST_MSB:FIRST_LSB]   = first;
        w[SECOND_MSB:SECOND_LSB] = second;
        return w;
    endfunction

endpackage

// File: rtl/i2s_rx_word_fifo.sv
// Small show-ahead synchronous word FIFO with flush and occupancy output.
module i2s_rx_word_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  level
);

    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   level_reg;
    logic [WORD_W-1:0]  entry_q [FIFO_DEPTH];
    logic               rd_ok;
    logic               wr_ok;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == (FIFO_AW+1)'(FIFO_DEPTH));
    assign level = level_reg;
    assign rd_ok = rd_en & ~empty;
    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign wr_ok = wr_en & (~full | rd_ok);
    assign rd_data = empty ? '0 : entry_q[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [WORD_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_ok && !flush && (wr_ptr_reg == FIFO_AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/i2s_rx_sample_packer.sv
// Pairs I2S receiver samples into 32-bit words, buffers them, and tracks drop/pairing errors.
module i2s_rx_sample_packer
    import i2s_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  i2s_clk_i,
    input  logic                  i2s_rst_n_i,
    input  logic                  enable_i,
    input  logic                  mono_mode_i,
    input  logic [SAMPLE_W-1:0]   data_left_i,
    input  logic [SAMPLE_W-1:0]   data_right_i,
    input  logic                  push_left_i,
    input  logic                  push_right_i,
    output logic [WORD_W-1:0]     word_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic [FIFO_AW:0]      fifo_level_o,
    output logic                  ovfl_o,
    output logic                  pair_err_o,
    input  logic                  err_clr_i,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    pk_state_e             state_reg, state_next;
    logic [SAMPLE_W-1:0]   held_reg, held_next;
    logic                  mono_prev_reg;
    logic                  ovfl_reg;
    logic                  pair_err_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic                  wr_req;
    logic [WORD_W-1:0]     wr_word;
    logic                  pair_evt;
    logic                  ovfl_evt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    always_comb begin
        state_next = state_reg;
        held_next  = held_reg;
        wr_req     = 1'b0;
        pair_evt   = 1'b0;
        wr_word    = pack_word(held_reg, mono_mode_i ? data_left_i : data_right_i);
        if (!enable_i) begin
            state_next = ST_IDLE;
            held_next  = '0;
        end else if (mono_mode_i != mono_prev_reg) begin
            // A mode switch while running invalidates any half-built word.
            state_next = ST_IDLE;
            held_next  = '0;
        end else if (push_left_i && push_right_i) begin
            pair_evt = 1'b1;
        end else if (mono_mode_i) begin
            if (push_left_i) begin
                if (state_reg == ST_IDLE) begin
                    held_next  = data_left_i;
                    state_next = ST_HAVE_L;
                end else begin
                    wr_req     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (push_left_i) begin
                        held_next  = data_left_i;
                        state_next = ST_HAVE_L;
                    end
                end
                ST_HAVE_L: begin
                    if (push_right_i) begin
                        wr_req     = 1'b1;
                        state_next = ST_IDLE;
                    end else if (push_left_i) begin
                        held_next = data_left_i;
                        pair_evt  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign pop      = ~fifo_empty & word_ready_i;
    assign ovfl_evt = wr_req & fifo_full & ~pop;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (ovfl_evt) begin
            if (err_clr_i)           drop_cnt_next = DROP_CNT_W'(1);
            else if (~&drop_cnt_reg) drop_cnt_next = drop_cnt_reg + 1'b1;
        end else if (err_clr_i) begin
            drop_cnt_next = '0;
        end
    end

    always_ff @(posedge i2s_clk_i or negedge i2s_rst_n_i) begin
        if (!i2s_rst_n_i) begin
            state_reg     <= ST_IDLE;
            held_reg      <= '0;
            mono_prev_reg <= 1'b0;
            ovfl_reg      <= 1'b0;
            pair_err_reg  <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            held_reg      <= held_next;
            mono_prev_reg <= mono_mode_i;
            ovfl_reg      <= ovfl_evt | (ovfl_reg & ~err_clr_i);
            pair_err_reg  <= pair_evt | (pair_err_reg & ~err_clr_i);
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    i2s_rx_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW),
        .WORD_W     (WORD_W)
    ) u_word_fifo (
        .clk     (i2s_clk_i),
        .rst_n   (i2s_rst_n_i),
        .flush   (~enable_i),
        .wr_en   (wr_req),
        .wr_data (wr_word),
        .rd_en   (word_ready_i),
        .rd_data (word_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    assign word_valid_o = ~fifo_empty;
    assign ovfl_o       = ovfl_reg;
    assign pair_err_o   = pair_err_reg;
    assign drop_cnt_o   = drop_cnt_reg;

endmodule

// File: doc/i2s_rx_sample_packer.md
Name: i2s_rx_sample_packer

Overview:
- Downstream neighbour of the I2S slave receiver, in the gated I2S bit-clock domain. Consumes its 16-bit left/right samples and their one-cycle push strobes.
- Pairs samples into 32-bit words: {left,right} in stereo, {left_n,left_n+1} in mono.
- Buffers words in a small synchronous FIFO with a valid/ready output, for the clock-crossing FIFO writer that follows.
- Reports overflow and pairing errors.

Parameters:
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)
FIFO_AW, 2, log2(FIFO_DEPTH)
DROP_CNT_W, 8, width of saturating dropped-word counter

Ports:
i2s_clk_i  input  1  I2S bit clock (global-buffered receiver clock)
i2s_rst_n_i  input  1  asynchronous active-low reset
enable_i  input  1  block enable; low = synchronous flush
mono_mode_i  input  1  1 = pack two consecutive left samples; right ignored
data_left_i  input  16  left sample, valid when push_left_i=1
data_right_i  input  16  right sample, valid when push_right_i=1
push_left_i  input  1  left sample complete strobe
push_right_i  input  1  right sample complete strobe
word_o  output  32  FIFO head word (show-ahead)
word_valid_o  output  1  FIFO non-empty
word_ready_i  input  1  consumer accepts head when valid & ready
fifo_level_o  output  FIFO_AW+1  current occupancy
ovfl_o  output  1  sticky: a completed word was dropped (FIFO full)
pair_err_o  output  1  sticky: left arrived while a left was held, or push strobes coincided
err_clr_i  input  1  synchronous clear of ovfl_o, pair_err_o, drop_cnt_o
drop_cnt_o  output  DROP_CNT_W  dropped-word count, saturates at all-ones

Behaviour:
- Reset (i2s_rst_n_i=0, async): FSM=IDLE, FIFO empty, held sample=0, all outputs 0. Reset mid-operation discards held sample and FIFO contents.
- enable_i=0, sampled each cycle: FSM->IDLE, FIFO pointers and level cleared, strobes ignored. Sticky flags and drop_cnt are retained.
- FSM states: IDLE, HAVE_L.
- Stereo, IDLE:
  - push_left: capture data_left_i, go to HAVE_L.
  - push_right: ignored; stream joined mid-frame, no error.
- Stereo, HAVE_L:
  - push_right: word={held_left,data_right_i} written, go to IDLE.
  - push_left: held_left replaced, stay in HAVE_L, pair_err_o set.
- Mono, IDLE: push_left captures to held, go to HAVE_L.
- Mono, HAVE_L: push_left writes word={held,data_left_i}, go to IDLE.
- Mono: push_right ignored in all states.
- mono_mode_i changes only while disabled. A change while enabled forces FSM to IDLE next cycle and discards the held sample.
- push_left_i & push_right_i both high: both ignored, FSM unchanged, pair_err_o set.
- Write latency: word written at the edge where the completing strobe is sampled. word_valid_o and word_o are valid the next cycle (1-cycle latency when FIFO was empty).
- Pop: valid & ready at an edge advances the head. word_o is combinational from the head entry register.
- Full + write, no pop: word dropped, ovfl_o set, drop_cnt_o +1, saturating.
- Full + write + pop in the same cycle: write accepted, level unchanged, no overflow.
- Empty + pop: impossible, since valid=0; ready is ignored.
- Pointers are FIFO_AW bits and wrap naturally. Level is FIFO_AW+1 bits, range 0..FIFO_DEPTH.
- err_clr_i clears the flags and counter. If a new error event occurs in the same cycle as err_clr_i, the event wins: flag=1, counter=1.

Decomposition:
- Package i2s_rx_pkg:
  - FSM state encoding (IDLE=1'b0, HAVE_L=1'b1)
  - SAMPLE_W=16, WORD_W=32
  - word field positions: left/first in [31:16], right/second in [15:0]
- Sub-module i2s_rx_word_fifo:
  - parameterised FIFO_DEPTH/FIFO_AW synchronous FIFO
  - inputs wr_en, rd_en, flush; outputs full, empty, level, head data
- Packer FSM and error logic stay in the top module.

Test Plan:
- Stereo: enable=1, push_left 16'hA5A5 then push_right 16'h5A5A, ready=0 -> next cycle word_valid_o=1, word_o=32'hA5A55A5A, fifo_level_o=1.
- Mid-frame join: first strobe push_right 16'h1111, then left 16'h2222 / right 16'h3333 -> exactly one word 32'h22223333; pair_err_o=0.
- Pair error: push_left 16'h0001, push_left 16'h0002, push_right 16'h0003 -> word 32'h00020003; pair_err_o=1 until err_clr_i.
- Overflow: ready=0, write 5 stereo pairs with FIFO_DEPTH=4 -> level=4, ovfl_o=1, drop_cnt_o=1; then ready=1 -> first 4 words drained in order, valid drops.
- Full + simultaneous pop/write: level=4, ready=1 in the cycle push_right completes a pair -> level stays 4, ovfl_o=0, new word last in order.
- Mono + flush: mono=1, lefts 16'hAAAA, 16'hBBBB -> word 32'hAAAABBBB. Then enable=0 one cycle -> level=0, valid=0, flags retained. Assert i2s_rst_n_i mid-pair -> all outputs 0 immediately.
